// File: rtl/ms_delay_timer.sv
// ms_delay_timer: millisecond countdown timer driven by an external 1 ms tick.
// A start in IDLE loads durationMs. Each msPulse in RUN counts down by one,
// and done pulses for one cycle when the count reaches zero. pause holds the
// count, and abort cancels the interval without a done pulse.
// Ports:
//   Clk, Rst       clock, asynchronous active-low reset
//   start          begin an interval (only honoured in IDLE)
//   durationMs     interval length in ms, captured when start is accepted
//   pause          level, freezes the countdown while high
//   abort          cancel a running/held interval, no done pulse
//   msPulse        one-cycle tick from the 1 ms pulse generator
//   tickEnable     enable to the 1 ms pulse generator (high only in RUN)
//   busy           interval in progress (RUN or HOLD)
//   done           one-cycle completion pulse
//   remaining      milliseconds left in the current interval
module ms_delay_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] durationMs,
  input  logic             pause,
  input  logic             abort,
  input  logic             msPulse,
  output logic             tickEnable,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] w_remaining_nxt;
  logic             r_tick_enable;
  logic             r_busy;
  logic             r_done;
  logic             w_tick_enable_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_last_tick;

  // This msPulse consumes the final millisecond.
  assign w_last_tick = msPulse && (r_remaining <= WIDTH'(1));

  // State, count and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= S_IDLE;
      r_remaining   <= '0;
      r_tick_enable <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_remaining   <= w_remaining_nxt;
      r_tick_enable <= w_tick_enable_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  // Next-state, next-count and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          // A zero-length interval still produces a single done pulse.
          if (durationMs == '0) begin
            w_state_nxt     = S_DONE;
            w_remaining_nxt = '0;
          end else begin
            w_state_nxt     = S_RUN;
            w_remaining_nxt = durationMs;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end else if (w_last_tick) begin
          // Completion wins over a pause that arrives in the same cycle.
          w_state_nxt     = S_DONE;
          w_remaining_nxt = '0;
        end else begin
          if (msPulse) begin
            w_remaining_nxt = r_remaining - WIDTH'(1);
          end
          if (pause) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (abort) begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end else if (!pause) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    w_tick_enable_nxt = (w_state_nxt == S_RUN);
    w_busy_nxt        = (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
    w_done_nxt        = (w_state_nxt == S_DONE);
  end

  assign tickEnable = r_tick_enable;
  assign busy       = r_busy;
  assign done       = r_done;
  assign remaining  = r_remaining;

endmodule

// File: tb/tb_ms_delay_timer.sv
// tb_ms_delay_timer: directed scenarios plus randomized stimulus for
// ms_delay_timer. Every cycle is compared against a behavioural interval model.
module tb_ms_delay_timer;

  localparam int unsigned W = 16;

  logic         Clk;
  logic         Rst;
  logic         start;
  logic [W-1:0] durationMs;
  logic         pause;
  logic         abort;
  logic         msPulse;
  logic         tickEnable;
  logic         busy;
  logic         done;
  logic [W-1:0] remaining;

  int n_checks;
  int n_errors;

  // Reference model: interval bookkeeping in plain variables.
  bit m_active;   // interval in progress
  bit m_held;     // countdown paused
  bit m_done;     // completion pulse this cycle
  int m_left;     // milliseconds left

  // Observation counters used by the directed scenarios.
  int done_seen;
  int busy_seen;
  int tick_seen;

  ms_delay_timer #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .durationMs (durationMs),
    .pause      (pause),
    .abort      (abort),
    .msPulse    (msPulse),
    .tickEnable (tickEnable),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_held   = 1'b0;
    m_done   = 1'b0;
    m_left   = 0;
  endtask

  // One clock edge of the interval rules.
  task automatic model_step(input bit s, input int d, input bit p, input bit a, input bit ms);
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (s) begin
        if (d == 0) begin
          m_done = 1'b1;
        end else begin
          m_active = 1'b1;
          m_held   = 1'b0;
          m_left   = d;
        end
      end
    end else if (a) begin
      m_active = 1'b0;
      m_held   = 1'b0;
      m_left   = 0;
    end else if (m_held) begin
      m_held = p;
    end else begin
      if (ms) m_left = m_left - 1;
      if (m_left <= 0) begin
        m_left   = 0;
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_held = p;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("tickEnable", 32'(tickEnable), 32'(m_active && !m_held));
    check_eq("busy",       32'(busy),       32'(m_active));
    check_eq("done",       32'(done),       32'(m_done));
    check_eq("remaining",  32'(remaining),  32'(m_left));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare after it.
  task automatic step(input bit s, input int d, input bit p, input bit a, input bit ms);
    start      = s;
    durationMs = W'(d);
    pause      = p;
    abort      = a;
    msPulse    = ms;
    @(posedge Clk);
    model_step(s, d, p, a, ms);
    #1;
    check_outputs();
    if (done === 1'b1) done_seen++;
    if (busy === 1'b1) busy_seen++;
    if (tickEnable === 1'b1) tick_seen++;
  endtask

  // Pull reset low between edges, check it acts without a clock edge,
  // then release it between edges.
  task automatic async_reset();
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge Clk);
    #1;
    check_outputs();
    #3;
    Rst = 1'b1;
  endtask

  task automatic clear_obs();
    done_seen = 0;
    busy_seen = 0;
    tick_seen = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    Rst        = 1'b1;
    start      = 1'b0;
    durationMs = '0;
    pause      = 1'b0;
    abort      = 1'b0;
    msPulse    = 1'b0;
    model_reset();
    clear_obs();

    // Reset state, checked before any clock edge.
    #2;
    Rst = 1'b0;
    #1;
    check_outputs();
    @(posedge Clk);
    #3;
    Rst = 1'b1;
    step(0, 0, 0, 0, 0);

    // Three-ms interval with a tick every fifth cycle.
    clear_obs();
    step(1, 3, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, (i % 5) == 4);
    check_eq("d3_done_count", 32'(done_seen), 32'd1);
    check_eq("d3_tick_after", 32'(tickEnable), 32'd0);

    // Zero-length interval.
    clear_obs();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("d0_done_count", 32'(done_seen), 32'd1);
    check_eq("d0_busy_seen",  32'(busy_seen), 32'd0);
    check_eq("d0_tick_seen",  32'(tick_seen), 32'd0);

    // Pause after two ticks, with msPulse toggling while held.
    clear_obs();
    step(1, 5, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, i[0]);
    check_eq("hold_remaining", 32'(remaining), 32'd3);
    check_eq("hold_busy",      32'(busy),      32'd1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, (i % 3) == 2);
    check_eq("pause_done_count", 32'(done_seen), 32'd1);

    // Pause and a tick in the same cycle: the tick still counts.
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Abort coincident with the second tick.
    clear_obs();
    step(1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    check_eq("abort_remaining", 32'(remaining), 32'd0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check_eq("abort_done_count", 32'(done_seen), 32'd0);

    // Abort on the final tick outranks completion.
    clear_obs();
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    check_eq("abort_last_done", 32'(done_seen), 32'd0);

    // Asynchronous reset after one tick, then a fresh interval.
    clear_obs();
    step(1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    async_reset();
    step(1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check_eq("rst_done_count", 32'(done_seen), 32'd1);

    // Restart during RUN is ignored.
    clear_obs();
    step(1, 2, 0, 0, 0);
    step(1, 9, 0, 0, 1);
    step(1, 9, 0, 0, 0);
    step(1, 9, 0, 0, 1);
    step(0, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("restart_done_count", 32'(done_seen), 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end
      step($urandom_range(0, 9) < 2, d, $urandom_range(0, 9) < 2,
           $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ms_delay_timer.md
MS_DELAY_TIMER -- requirements
Module: ms_delay_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of duration and remaining count.
REQ-002 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a timed interval; sampled only in IDLE.
REQ-005 SHALL have port durationMs  input  WIDTH  interval length in milliseconds; sampled in the cycle start is accepted.
REQ-006 SHALL have port pause  input  1  level; holds the countdown while high.
REQ-007 SHALL have port abort  input  1  cancels a running interval with no done pulse.
REQ-008 SHALL have port msPulse  input  1  one-cycle tick from the 1 ms pulse generator.
REQ-009 SHALL have port tickEnable  output  1  enable to the 1 ms pulse generator.
REQ-010 SHALL have port busy  output  1  high while an interval is in progress (RUN or HOLD).
REQ-011 SHALL have port done  output  1  one-cycle pulse at interval completion.
REQ-012 SHALL have port remaining  output  WIDTH  milliseconds left in the current interval.

Function
REQ-013 SHALL implement states IDLE, RUN, HOLD, DONE; all outputs registered.
REQ-014 IDLE: tickEnable=0, busy=0, done=0; start=1 with durationMs!=0 -> remaining<=durationMs, go RUN next cycle.
REQ-015 IDLE: start=1 with durationMs==0 -> remaining stays 0, go DONE (zero-length interval still yields one done pulse).
REQ-016 RUN: tickEnable=1, busy=1; msPulse=1 -> remaining decrements by 1.
REQ-017 RUN: msPulse=1 while remaining==1 -> remaining<=0, go DONE; remaining never wraps below 0.
REQ-018 RUN: pause=1 -> go HOLD; a msPulse in that same cycle is still counted (pause takes effect next cycle).
REQ-019 HOLD: tickEnable=0 (pulse generator restarts its 1 ms window on resume), busy=1, remaining frozen, msPulse ignored; pause=0 -> return to RUN.
REQ-020 abort=1 in RUN or HOLD -> go IDLE, remaining<=0, no done pulse; abort outranks msPulse, pause and completion in the same cycle.
REQ-021 DONE: done=1, busy=0, tickEnable=0 for exactly one cycle, then IDLE unconditionally.
REQ-022 start SHALL be ignored in RUN, HOLD and DONE; abort SHALL be ignored in IDLE and DONE.
REQ-023 Latency: done asserts in the cycle after the clock edge that samples the final msPulse.
REQ-024 durationMs SHALL NOT be resampled after acceptance; later changes have no effect on the running interval.

Reset
REQ-025 Rst=0 SHALL immediately force state IDLE, remaining=0, tickEnable=0, busy=0, done=0, independent of Clk.
REQ-026 Reset asserted mid-interval SHALL discard the interval with no done pulse; first start is accepted on the first rising edge after Rst returns high.

Verification
REQ-027 Reset, start=1 durationMs=3, msPulse every 5th cycle -> busy high, remaining 3,2,1,0; done pulses once, one cycle after third msPulse; tickEnable low afterwards.
REQ-028 start=1 durationMs=0 -> done pulses one cycle after acceptance (DONE then IDLE), busy never high, tickEnable never high.
REQ-029 durationMs=5, after 2 ticks pause=1 for 20 cycles with msPulse toggling -> remaining holds 3, tickEnable low, busy high; after release remaining counts 3->0 and done pulses.
REQ-030 durationMs=4, abort=1 coincident with the second msPulse -> IDLE next cycle, remaining=0, no done pulse, busy low.
REQ-031 durationMs=2, Rst pulled low between clock edges after 1 tick -> outputs clear without a clock edge; done never pulses; new start after release runs normally.
REQ-032 start re-asserted during RUN with durationMs=9 (interval 2) -> ignored; only the original interval counts down and done pulses once.
